// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif
//   I2C target with a simple register interface. SCL and SDA are synchronized
//   and oversampled on clk. The block decodes START/STOP, a 7-bit address,
//   an 8-bit sub-address pointer and data bytes. Writes leave on a one-clk
//   reg_we strobe. Reads enter through reg_re/reg_rdata. SDA is open-drain:
//   the block only requests a low level.
//
// Ports
//   clk              system clock, at least 16x the SCL frequency
//   reset            asynchronous, active-low
//   i2c_scl_in       raw SCL pin level
//   i2c_sda_in       raw SDA pin level
//   i2c_sda_out_mode 1 = pull SDA low, 0 = release
//   reg_addr         sub-address pointer
//   reg_wdata        write data, valid while reg_we = 1
//   reg_we           one-clk write strobe
//   reg_re           one-clk read request for reg_addr
//   reg_rdata        read data, captured one clk after the reg_re cycle
//   busy             high from an address match until STOP or a read NACK
module i2c_slave_regif #(
    parameter logic [6:0]  ADDR        = 7'b1101000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_out_mode,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge / condition detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda_in};
    end

    // Synchronizers reset to 1 so an idle bus after reset shows no edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // ------------------------------------------------------------------
    // Protocol state machine
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       latch_q, latch_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic [7:0] rx_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            latch_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            latch_q   <= latch_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        latch_d   = 1'b0;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        rx_byte   = {shift_q[6:0], sda_s};

        // Pointer advances the clk after a write strobe.
        if (we_q) begin
            ptr_d = ptr_q + 8'd1;
        end
        // Read data arrives one clk after the reg_re cycle.
        if (re_q) begin
            latch_d = 1'b1;
        end

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (rx_byte[7:1] == ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                re_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == ST_SUB) begin
                                ptr_d   = rx_byte;
                                state_d = ST_SUB_ACK;
                            end else begin
                                wdata_d = rx_byte;
                                we_d    = 1'b1;
                                state_d = ST_WDATA_ACK;
                            end
                        end
                    end
                end

                // bit_cnt marks whether the ACK low has been driven yet:
                // first fall drives it, second fall ends the ACK slot.
                ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            bit_cnt_d = '0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d  = ST_RDATA;
                                sda_oe_d = ~shift_q[7];
                            end else begin
                                state_d  = (state_q == ST_ADDR_ACK) ? ST_SUB : ST_WDATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end

                // Bit 7 is already on the bus on entry; each fall after a
                // rise shifts the next bit out until all eight have gone.
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RDATA_MACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                ST_RDATA_MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            re_d      = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d  = ST_IDLE;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
                        sda_oe_d  = ~shift_q[7];
                    end
                end

                default: begin
                end
            endcase
        end

        if (latch_q) begin
            shift_d = reg_rdata;
            ptr_d   = ptr_q + 8'd1;
        end
    end

    assign i2c_sda_out_mode = sda_oe_q;
    assign reg_addr         = ptr_q;
    assign reg_wdata        = wdata_q;
    assign reg_we           = we_q;
    assign reg_re           = re_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
module tb_i2c_slave_regif;

    localparam int Q = 5;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic       sda_line;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_we, reg_re, busy;
    logic [7:0] reg_rdata = 8'h00;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Wired-AND open-drain bus
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regif #(.ADDR(7'b1101000), .SYNC_STAGES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .i2c_scl_in       (scl_m),
        .i2c_sda_in       (sda_line),
        .i2c_sda_out_mode (sda_oe),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_we           (reg_we),
        .reg_re           (reg_re),
        .reg_rdata        (reg_rdata),
        .busy             (busy)
    );

    // Monitors / register-file model
    logic [7:0] we_a_log [0:63];
    logic [7:0] we_d_log [0:63];
    logic [7:0] re_a_log [0:63];
    logic [7:0] rd_tab   [0:3];
    int we_n = 0, re_n = 0, low_n = 0, busy_n = 0, coll_n = 0;

    always @(negedge clk) begin
        if (reg_we) begin
            we_a_log[we_n % 64] = reg_addr;
            we_d_log[we_n % 64] = reg_wdata;
            we_n++;
        end
        if (reg_re) begin
            re_a_log[re_n % 64] = reg_addr;
            reg_rdata = rd_tab[re_n % 4];
            re_n++;
        end
        if (reg_we && reg_re) coll_n++;
        if (sda_oe) low_n++;
        if (busy) busy_n++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        @(negedge clk);
        b = sda_line;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic mack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
        write_bit(mack);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] s;
        logic [7:0] d;
        logic       exp_ack;   // level read in every 9th clock
        int         exp_we;
        logic [7:0] exp_ptr;
    } vec_t;

    vec_t vecs [0:3];

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         we0, re0, low0, busy0, n;

        vecs[0] = '{a: 8'hD0, s: 8'h20, d: 8'h0F, exp_ack: 1'b0, exp_we: 1, exp_ptr: 8'h21};
        vecs[1] = '{a: 8'hA0, s: 8'h20, d: 8'h55, exp_ack: 1'b1, exp_we: 0, exp_ptr: 8'h21};
        vecs[2] = '{a: 8'hD0, s: 8'hFF, d: 8'hAA, exp_ack: 1'b0, exp_we: 1, exp_ptr: 8'h00};
        vecs[3] = '{a: 8'hD0, s: 8'h7F, d: 8'h01, exp_ack: 1'b0, exp_we: 1, exp_ptr: 8'h80};
        rd_tab[0] = 8'h00; rd_tab[1] = 8'h00; rd_tab[2] = 8'h00; rd_tab[3] = 8'h00;

        // Reset
        #2 reset = 1'b0;
        wait_clk(4);
        @(negedge clk);
        check("rst_sda", sda_oe, 0);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_we_re_busy", {reg_we, reg_re, busy}, 3'b000);
        reset = 1'b1;
        wait_clk(4);

        // Single-byte write transactions from the table
        for (int v = 0; v < 4; v++) begin
            we0 = we_n; re0 = re_n; low0 = low_n; busy0 = busy_n;
            i2c_start();
            send_byte(vecs[v].a, ack); check($sformatf("v%0d_ack_addr", v), ack, vecs[v].exp_ack);
            send_byte(vecs[v].s, ack); check($sformatf("v%0d_ack_sub", v), ack, vecs[v].exp_ack);
            send_byte(vecs[v].d, ack); check($sformatf("v%0d_ack_data", v), ack, vecs[v].exp_ack);
            i2c_stop();
            wait_clk(4);
            @(negedge clk);
            check($sformatf("v%0d_we_count", v), we_n - we0, vecs[v].exp_we);
            if (vecs[v].exp_we == 1) begin
                check($sformatf("v%0d_we_addr", v), we_a_log[we0 % 64], vecs[v].s);
                check($sformatf("v%0d_we_data", v), we_d_log[we0 % 64], vecs[v].d);
            end
            check($sformatf("v%0d_ptr", v), reg_addr, vecs[v].exp_ptr);
            check($sformatf("v%0d_re_count", v), re_n - re0, 0);
            check($sformatf("v%0d_busy_seen", v), busy_n > busy0, !vecs[v].exp_ack);
            check($sformatf("v%0d_sda_low_seen", v), low_n > low0, !vecs[v].exp_ack);
            check($sformatf("v%0d_idle", v), {busy, sda_oe}, 2'b00);
        end

        // Burst write with pointer wrap
        we0 = we_n;
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'hFE, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack);
        send_byte(8'h33, ack); check("burst_last_ack", ack, 0);
        i2c_stop();
        wait_clk(4);
        @(negedge clk);
        check("burst_we_count", we_n - we0, 3);
        check("burst_w0", {we_a_log[(we0) % 64], we_d_log[(we0) % 64]}, 16'hFE11);
        check("burst_w1", {we_a_log[(we0 + 1) % 64], we_d_log[(we0 + 1) % 64]}, 16'hFF22);
        check("burst_w2", {we_a_log[(we0 + 2) % 64], we_d_log[(we0 + 2) % 64]}, 16'h0033);
        check("burst_ptr", reg_addr, 8'h01);

        // Write sub-address, repeated START, read two bytes
        we0 = we_n; re0 = re_n;
        rd_tab[re_n % 4]       = 8'h5A;
        rd_tab[(re_n + 1) % 4] = 8'hC3;
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'h20, ack); check("rd_sub_ack", ack, 0);
        i2c_start();
        send_byte(8'hD1, ack); check("rd_addr_ack", ack, 0);
        recv_byte(rb, 1'b0);   check("rd_byte0", rb, 8'h5A);
        recv_byte(rb, 1'b1);   check("rd_byte1", rb, 8'hC3);
        @(negedge clk);
        check("rd_nack_idle", {busy, sda_oe}, 2'b00);
        i2c_stop();
        wait_clk(4);
        @(negedge clk);
        check("rd_re_count", re_n - re0, 2);
        check("rd_re_addr0", re_a_log[re0 % 64], 8'h20);
        check("rd_re_addr1", re_a_log[(re0 + 1) % 64], 8'h21);
        check("rd_we_count", we_n - we0, 0);
        check("rd_ptr", reg_addr, 8'h22);

        // STOP after 4 bits of a data byte, then a normal write
        we0 = we_n;
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'h40, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        wait_clk(4);
        @(negedge clk);
        check("abort_we_count", we_n - we0, 0);
        check("abort_idle", {busy, sda_oe}, 2'b00);
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'h41, ack);
        send_byte(8'h99, ack); check("after_abort_ack", ack, 0);
        i2c_stop();
        wait_clk(4);
        @(negedge clk);
        check("after_abort_we", {we_a_log[we0 % 64], we_d_log[we0 % 64]}, 16'h4199);
        check("after_abort_ptr", reg_addr, 8'h42);

        // Reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(rb_const(i));
        n = 0;
        while (sda_oe !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_before_reset", sda_oe, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rst_sda", sda_oe, 0);
        check("async_rst_addr", reg_addr, 8'h00);
        check("async_rst_wdata", reg_wdata, 8'h00);
        check("async_rst_flags", {reg_we, reg_re, busy}, 3'b000);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(4);
        @(negedge clk);
        check("never_we_and_re", coll_n, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Bits of the 0xD0 address byte used in the reset scenario
    function automatic logic rb_const(input int i);
        logic [7:0] b;
        b = 8'hD0;
        return b[i];
    endfunction

endmodule
